icache_model: RTL and testbench
===============================

# icache_model

Parametrised, cycle-accurate instruction-cache responder for frontend testbenches; synthesizable successor to the fixed-latency dummy cache model. Accepts fetch addresses over a valid/ready handshake and queues up to DEPTH outstanding requests. Returns in-order `icache_out_t` lines after a programmable hit latency, with a periodic extra miss penalty. Supports a flush that drops all in-flight requests, as needed by the frontend when it redirects on branch mispredicts.

## Interface
- ADDR_LATENCY, 0: busy cycles with addr_ready_o low after each accepted address.
- DATA_LATENCY, 0: extra cycles before a hit response (0..15).
- MISS_EVERY, 0: every MISS_EVERY-th accepted request is a miss; 0 disables misses.
- MISS_LATENCY, 4: additional cycles added to a miss response (0..255).
- DEPTH, 4: outstanding-request queue depth; power of two, ≥2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drops all queued requests and any pending response.
- addr_i  in  XLEN  fetch address.
- addr_valid_i  in  1  address valid.
- addr_ready_o  out  1  address accepted when addr_valid_i & addr_ready_o at a clock edge.
- data_o  out  icache_out_t  response: pc and line[0..ICACHE_INSTR-1].
- data_valid_o  out  1  response valid; held until it is consumed.
- data_ready_i  in  1  consumer ready; transfer when data_valid_o & data_ready_i.

## Operation
- Queue: a DEPTH-entry FIFO holding {addr, miss flag}, with a count of 0..DEPTH.
- addr_ready_o = !rst_i & !flush_i & (count < DEPTH) & (busy counter == 0). It is combinational on registered state, flush_i and rst_i.
- Full queue: addr_ready_o is low even if a pop occurs in the same cycle.
- Accept: push {addr_i, miss}. Load the busy counter with ADDR_LATENCY.
  - The request counter increments modulo MISS_EVERY.
  - miss = (MISS_EVERY ≠ 0) & (counter value before increment == MISS_EVERY-1).
- Wait counter: loaded on the edge where an entry becomes head.
  - An entry becomes head by a push into an empty queue or by a pop that leaves a successor.
  - Load value L = DATA_LATENCY + (miss ? MISS_LATENCY : 0). It decrements to 0 and saturates there.
- Pop/load: at an edge where the queue is non-empty, the wait counter is 0, and (!data_valid_o | data_ready_i):
  - data_o.pc <= head addr.
  - data_o.line[i] <= head addr + 4·i, truncated to the line element width, for i = 0..ICACHE_INSTR-1.
  - data_valid_o <= 1, and the head is popped.
- Consume without reload: data_valid_o <= 0. data_o keeps its last value.
- Simultaneous push and pop: count unchanged. The push into a 1-entry queue that pops becomes the new head, and its counter is loaded with its L.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not by pointers.
- Flush (priority over everything except reset):
  - count, pointers, busy and wait counters <= 0; data_valid_o <= 0.
  - A data handshake in the flush cycle counts as completed for the consumer. The model discards its state regardless.
  - The miss request counter is NOT cleared.
- Reset: everything cleared, including the request counter.

## Timing
- Reset values: addr_ready_o 0 while rst_i is high, 1 in the first cycle after; data_valid_o 0; data_o all zeros.
- Latency: an address accepted at edge E into an empty queue, with the output free, gives data_valid_o high from edge E+1+L.
- Throughput: with all latencies 0 and data_ready_i held 1, the model sustains one request and one response per cycle, and the queue never exceeds 1.
- Address rate: with ADDR_LATENCY = A, at most one accept per A+1 cycles.
- Backpressure: data_valid_o/data_o stay stable while data_ready_i is low. Queued entries whose counters reach 0 wait.
- Reset mid-operation takes effect at the next edge; outstanding responses are lost.

## Test plan
- All latencies 0, DEPTH 4; addresses 0x100, 0x110, 0x120 on consecutive cycles; data_ready_i = 1.
  -> responses at edges E+1, E+2, E+3 with pc 0x100/0x110/0x120; line[1] = 0x104/0x114/0x124.
- DATA_LATENCY 2, MISS_EVERY 3, MISS_LATENCY 4; six spaced requests.
  -> latencies 3, 3, 7, 3, 3, 7 cycles.
- data_ready_i held 0; issue requests continuously.
  -> exactly DEPTH+1 accepts (4 queued + 1 in the output register), then addr_ready_o stays 0. Draining returns all five in order.
- ADDR_LATENCY 2; addr_valid_i held 1.
  -> addr_ready_o pattern 1,0,0,1,0,0.
- Three requests in flight; pulse flush_i for one cycle.
  -> data_valid_o 0 next cycle, no stale response ever appears. A new request at 0x200 returns pc 0x200 with normal latency.
- Assert rst_i for one cycle mid-stream.
  -> addr_ready_o 0 during reset, data_valid_o 0 after it. The miss sequence restarts from count 0.

Source files
------------

// File: rtl/icache_model_if.sv
// Shared payload type and fetch/response bus for the instruction-cache responder.
package icache_model_pkg;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned ILEN         = 32;
    localparam int unsigned ICACHE_INSTR = 4;

    typedef struct packed {
        logic [XLEN-1:0]                   pc;
        logic [ICACHE_INSTR-1:0][ILEN-1:0] line;
    } icache_out_t;
endpackage

interface icache_model_if;
    import icache_model_pkg::*;

    logic            flush_i;
    logic [XLEN-1:0] addr_i;
    logic            addr_valid_i;
    logic            addr_ready_o;
    icache_out_t     data_o;
    logic            data_valid_o;
    logic            data_ready_i;

    modport master (
        output flush_i, addr_i, addr_valid_i, data_ready_i,
        input  addr_ready_o, data_o, data_valid_o
    );

    modport slave (
        input  flush_i, addr_i, addr_valid_i, data_ready_i,
        output addr_ready_o, data_o, data_valid_o
    );
endinterface

// File: rtl/icache_model.sv
// Cycle-accurate instruction-cache responder: queued fetches, programmable hit
// latency, periodic miss penalty and a flush that drops everything in flight.
module icache_model
    import icache_model_pkg::*;
#(
    parameter int unsigned ADDR_LATENCY = 0,
    parameter int unsigned DATA_LATENCY = 0,
    parameter int unsigned MISS_EVERY   = 0,
    parameter int unsigned MISS_LATENCY = 4,
    parameter int unsigned DEPTH        = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    icache_model_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BUSY_W = $clog2(ADDR_LATENCY + 2);
    localparam int unsigned WAIT_W = $clog2(DATA_LATENCY + MISS_LATENCY + 2);
    localparam int unsigned REQ_W  = $clog2(MISS_EVERY + 2);

    logic [XLEN-1:0]   q_addr [DEPTH];
    logic [DEPTH-1:0]  q_miss;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0]  count;
    logic [BUSY_W-1:0] busy;
    logic [WAIT_W-1:0] wait_cnt;
    logic [REQ_W-1:0]  req_cnt;
    logic              push, pop, new_miss;
    logic [XLEN-1:0]   head_addr;

    function automatic logic [WAIT_W-1:0] lat_of(input logic miss);
        return WAIT_W'(DATA_LATENCY) + (miss ? WAIT_W'(MISS_LATENCY) : WAIT_W'(0));
    endfunction

    assign bus.addr_ready_o = !rst_i && !bus.flush_i && (count < CNT_W'(DEPTH)) && (busy == '0);
    assign push      = bus.addr_valid_i && bus.addr_ready_o;
    assign pop       = (count != '0) && (wait_cnt == '0) && (!bus.data_valid_o || bus.data_ready_i);
    assign new_miss  = (MISS_EVERY != 0) && (req_cnt == REQ_W'(MISS_EVERY - 1));
    assign rd_next   = rd_ptr + PTR_W'(1);
    assign head_addr = q_addr[rd_ptr];

    // Request storage; push is already blocked during reset and flush.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.addr_i;
            q_miss[wr_ptr] <= new_miss;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            busy             <= '0;
            wait_cnt         <= '0;
            req_cnt          <= '0;
            bus.data_valid_o <= 1'b0;
            bus.data_o       <= '0;
        end else if (bus.flush_i) begin
            // The miss request counter deliberately survives a flush.
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            busy             <= '0;
            wait_cnt         <= '0;
            bus.data_valid_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                busy   <= BUSY_W'(ADDR_LATENCY);
                if (MISS_EVERY != 0)
                    req_cnt <= new_miss ? '0 : req_cnt + REQ_W'(1);
            end else if (busy != '0) begin
                busy <= busy - BUSY_W'(1);
            end

            if (pop) begin
                rd_ptr           <= rd_next;
                bus.data_valid_o <= 1'b1;
                bus.data_o.pc    <= head_addr;
                for (int unsigned i = 0; i < ICACHE_INSTR; i++)
                    bus.data_o.line[i] <= ILEN'(head_addr + XLEN'(4 * i));
            end else if (bus.data_ready_i) begin
                bus.data_valid_o <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Reload on the edge a new entry reaches the head, otherwise count down.
            if (push && ((count == '0) || (pop && count == CNT_W'(1))))
                wait_cnt <= lat_of(new_miss);
            else if (pop && count > CNT_W'(1))
                wait_cnt <= lat_of(q_miss[rd_next]);
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end
endmodule

// File: tb/tb_icache_model.sv
// Scoreboard bench for icache_model: two configurations share one stimulus
// stream and are checked against an event-time model of queue and output.
module tb_icache_model;
    import icache_model_pkg::*;

    localparam int NI = 2;
    localparam int DW = $bits(icache_out_t);
    localparam int RB = 16;
    localparam int CFG_A  [NI] = '{0, 2};
    localparam int CFG_DL [NI] = '{0, 2};
    localparam int CFG_ME [NI] = '{0, 3};
    localparam int CFG_ML [NI] = '{4, 4};
    localparam int CFG_D  [NI] = '{4, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, valid, dready, end_chk;
    logic [XLEN-1:0] addr;

    icache_model_if bus0 ();
    icache_model_if bus1 ();

    assign bus0.flush_i = flush;  assign bus1.flush_i = flush;
    assign bus0.addr_i  = addr;   assign bus1.addr_i  = addr;
    assign bus0.addr_valid_i = valid;  assign bus1.addr_valid_i = valid;
    assign bus0.data_ready_i = dready; assign bus1.data_ready_i = dready;

    icache_model #(.ADDR_LATENCY(CFG_A[0]), .DATA_LATENCY(CFG_DL[0]), .MISS_EVERY(CFG_ME[0]),
                   .MISS_LATENCY(CFG_ML[0]), .DEPTH(CFG_D[0]))
        u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    icache_model #(.ADDR_LATENCY(CFG_A[1]), .DATA_LATENCY(CFG_DL[1]), .MISS_EVERY(CFG_ME[1]),
                   .MISS_LATENCY(CFG_ML[1]), .DEPTH(CFG_D[1]))
        u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: pending requests with the edge at which each became head.
    int unsigned m_addr [NI][RB];
    bit          m_miss [NI][RB];
    int          m_head [NI], m_cnt [NI], acc_k [NI], last_e [NI], head_h [NI];
    bit          busy_on [NI];
    int          edge_n = 0;
    bit          have_prev = 0;

    logic            p_rst, p_flush, p_valid, p_dready;
    logic [XLEN-1:0] p_addr;
    logic            p_ready [NI], p_ovalid [NI];
    icache_out_t     p_data [NI];
    logic            c_ready [NI], c_ovalid [NI];
    icache_out_t     c_data [NI];

    function automatic icache_out_t expect_line(input int unsigned a);
        icache_out_t e;
        e.pc = XLEN'(a);
        for (int i = 0; i < ICACHE_INSTR; i++) e.line[i] = ILEN'(a + 32'(4 * i));
        return e;
    endfunction

    always @(negedge clk) begin
        c_ready[0] = bus0.addr_ready_o; c_ovalid[0] = bus0.data_valid_o; c_data[0] = bus0.data_o;
        c_ready[1] = bus1.addr_ready_o; c_ovalid[1] = bus1.data_valid_o; c_data[1] = bus1.data_o;
        if (have_prev) begin
            edge_n++;
            for (int k = 0; k < NI; k++) begin
                if (p_rst) begin
                    chk("reset_valid", k, DW'(c_ovalid[k]), DW'(0));
                    chk("reset_data", k, c_data[k], '0);
                    m_cnt[k] = 0; acc_k[k] = 0; busy_on[k] = 0;
                end else if (p_flush) begin
                    chk("flush_valid", k, DW'(c_ovalid[k]), DW'(0));
                    m_cnt[k] = 0; busy_on[k] = 0;
                end else begin
                    bit exp_pop, obs_pop;
                    int lat;
                    lat = CFG_DL[k] + (m_miss[k][m_head[k]] ? CFG_ML[k] : 0);
                    exp_pop = (m_cnt[k] > 0) && (edge_n >= head_h[k] + lat + 1) &&
                              (!p_ovalid[k] || p_dready);
                    obs_pop = c_ovalid[k] && (!p_ovalid[k] || p_dready);
                    chk("pop_timing", k, DW'(obs_pop), DW'(exp_pop));
                    if (obs_pop && m_cnt[k] > 0) begin
                        chk("resp_data", k, c_data[k], expect_line(m_addr[k][m_head[k]]));
                        m_head[k] = (m_head[k] + 1) % RB;
                        m_cnt[k]--;
                        if (m_cnt[k] > 0) head_h[k] = edge_n;
                    end else if (p_ovalid[k] && !p_dready) begin
                        chk("hold_valid", k, DW'(c_ovalid[k]), DW'(1));
                        chk("hold_data", k, c_data[k], p_data[k]);
                    end else if (!obs_pop) begin
                        chk("data_keep", k, c_data[k], p_data[k]);
                    end
                    if (p_valid && p_ready[k]) begin
                        int t;
                        t = (m_head[k] + m_cnt[k]) % RB;
                        m_addr[k][t] = p_addr;
                        m_miss[k][t] = (CFG_ME[k] != 0) && (acc_k[k] % CFG_ME[k] == CFG_ME[k] - 1);
                        acc_k[k]++;
                        if (m_cnt[k] == 0) head_h[k] = edge_n;
                        m_cnt[k]++;
                        last_e[k] = edge_n;
                        busy_on[k] = 1;
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            bit exp_rdy;
            exp_rdy = !rst && !flush && (m_cnt[k] < CFG_D[k]) &&
                      !(busy_on[k] && edge_n < last_e[k] + CFG_A[k]);
            chk("addr_ready", k, DW'(c_ready[k]), DW'(exp_rdy));
            if (end_chk) chk("drained", k, DW'(m_cnt[k]), DW'(0));
        end
        p_rst = rst; p_flush = flush; p_valid = valid; p_dready = dready; p_addr = addr;
        for (int k = 0; k < NI; k++) begin
            p_ready[k] = c_ready[k]; p_ovalid[k] = c_ovalid[k]; p_data[k] = c_data[k];
        end
        have_prev = 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; dready = 1'b0; addr = '0; end_chk = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Back-to-back fetches with the consumer always ready.
        dready = 1'b1; valid = 1'b1;
        addr = 32'h100; cyc(1);
        addr = 32'h110; cyc(1);
        addr = 32'h120; cyc(1);
        valid = 1'b0; cyc(10);

        // Spaced requests expose hit and miss latencies.
        for (int i = 0; i < 6; i++) begin
            addr = 32'h1000 + 32'(16 * i); valid = 1'b1; cyc(1);
            valid = 1'b0; cyc(14);
        end

        // Consumer stalled: queue and output register fill, then drain.
        dready = 1'b0; valid = 1'b1;
        for (int i = 0; i < 20; i++) begin addr = 32'h2000 + 32'(16 * i); cyc(1); end
        valid = 1'b0; cyc(5);
        dready = 1'b1; cyc(20);

        // Continuous valid shows the address-rate limit.
        valid = 1'b1;
        for (int i = 0; i < 12; i++) begin addr = 32'h2800 + 32'(4 * i); cyc(1); end
        valid = 1'b0; cyc(10);

        // Flush with requests in flight, then a fresh request.
        dready = 1'b0; valid = 1'b1;
        addr = 32'h3000; cyc(1);
        addr = 32'h3010; cyc(1);
        addr = 32'h3020; cyc(1);
        valid = 1'b0; dready = 1'b1; flush = 1'b1; cyc(1);
        flush = 1'b0; cyc(2);
        addr = 32'h200; valid = 1'b1; cyc(1);
        valid = 1'b0; cyc(15);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 3) != 0);
            addr   = $urandom;
            dready = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 59) == 0);
            rst    = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        flush = 1'b0; rst = 1'b0;

        // Reset in the middle of a stream.
        valid = 1'b1; dready = 1'b1;
        for (int i = 0; i < 6; i++) begin addr = 32'h4000 + 32'(16 * i); cyc(1); end
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin addr = 32'h5000 + 32'(16 * i); cyc(1); end

        valid = 1'b0; dready = 1'b1;
        cyc(400);
        end_chk = 1'b1; cyc(1);
        end_chk = 1'b0; cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
